// File: rtl/decode_stage.sv
// RV64I instruction decode stage: register-file addressing, immediate/control generation,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned REG_COUNT = 32,
  localparam int unsigned RA       = $clog2(REG_COUNT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            id_stall,
  output logic [RA-1:0]   raddr1,
  output logic [RA-1:0]   raddr2,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  input  logic            flush,
  input  logic            ex_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA-1:0]   ex_rs1,
  output logic [RA-1:0]   ex_rs2,
  output logic [RA-1:0]   ex_rd,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_alu_src_imm,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_illegal
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpReg32  = 7'b0111011;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [RA-1:0]   rs1;
    logic [RA-1:0]   rs2;
    logic [RA-1:0]   rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            alu_src_imm;
    logic            branch;
    logic            jump;
    logic            illegal;
  } idex_t;

  idex_t idex_q, idex_d, dec;
  logic  use_rs1, use_rs2, hazard;

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign raddr1 = if_instr[15 +: RA];
  assign raddr2 = if_instr[20 +: RA];

  assign imm_i = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                  if_instr[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                  if_instr[30:21], 1'b0};

  always_comb begin
    dec          = '0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    dec.valid    = 1'b1;
    dec.pc       = if_pc;
    dec.rs1_val  = rdata1;
    dec.rs2_val  = rdata2;
    dec.rs1      = if_instr[15 +: RA];
    dec.rs2      = if_instr[20 +: RA];
    dec.rd       = if_instr[7 +: RA];
    dec.opcode   = if_instr[6:0];
    dec.funct3   = if_instr[14:12];
    dec.funct7b5 = if_instr[30];
    case (if_instr[6:0])
      OpLui, OpAuipc: begin
        dec.imm = imm_u; dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1;
      end
      OpJal: begin
        dec.imm = imm_j; dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.jump = 1'b1;
      end
      OpJalr: begin
        dec.imm = imm_i; use_rs1 = 1'b1;
        dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.jump = 1'b1;
      end
      OpLoad: begin
        dec.imm = imm_i; use_rs1 = 1'b1;
        dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1; dec.mem_read = 1'b1;
      end
      OpImm, OpImm32: begin
        dec.imm = imm_i; use_rs1 = 1'b1; dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1;
      end
      OpStore: begin
        dec.imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.mem_write = 1'b1; dec.alu_src_imm = 1'b1;
      end
      OpBranch: begin
        dec.imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; dec.branch = 1'b1;
      end
      OpReg, OpReg32: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Writes to x0 are architecturally discarded, so never advertise them downstream.
    if (dec.rd == '0) dec.reg_write = 1'b0;
  end

  assign hazard = if_valid & idex_q.valid & idex_q.mem_read & (idex_q.rd != '0) &
                  ((use_rs1 & (dec.rs1 == idex_q.rd)) | (use_rs2 & (dec.rs2 == idex_q.rd)));

  assign id_stall = ~flush & (ex_stall | hazard);

  always_comb begin
    idex_d = idex_q;
    if (flush) begin
      idex_d = '0;
    end else if (ex_stall) begin
      idex_d = idex_q;
    end else if (hazard || !if_valid) begin
      idex_d = '0;
    end else begin
      idex_d = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign ex_valid       = idex_q.valid;
  assign ex_pc          = idex_q.pc;
  assign ex_rs1_val     = idex_q.rs1_val;
  assign ex_rs2_val     = idex_q.rs2_val;
  assign ex_imm         = idex_q.imm;
  assign ex_rs1         = idex_q.rs1;
  assign ex_rs2         = idex_q.rs2;
  assign ex_rd          = idex_q.rd;
  assign ex_opcode      = idex_q.opcode;
  assign ex_funct3      = idex_q.funct3;
  assign ex_funct7b5    = idex_q.funct7b5;
  assign ex_mem_read    = idex_q.mem_read;
  assign ex_mem_write   = idex_q.mem_write;
  assign ex_reg_write   = idex_q.reg_write;
  assign ex_alu_src_imm = idex_q.alu_src_imm;
  assign ex_branch      = idex_q.branch;
  assign ex_jump        = idex_q.jump;
  assign ex_illegal     = idex_q.illegal;

endmodule
